uart_autobaud: RTL and testbench

Automatic baud-rate detector for the UART receive path. After being armed it watches the raw RX line for a 0x55 sync character and measures eight bit periods. It then selects the nearest of the eight supported rates and drives the 3-bit baud code that configures the baud generator. It sits between the register block (start/abort control, status) and the baud generator's `i_baud_rate` input.

---
 rtl/uart_autobaud.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_autobaud.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// rtl/uart_autobaud.sv - automatic baud-rate detector locking onto a 0x55 sync character
//
// Purpose:
//   Once armed, waits for the RX line to sit idle-high, times the five falling
//   edges of a 0x55 character (eight bit periods) and picks the nearest of the
//   eight supported baud codes for the baud generator.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous reset, active-high
//   i_start      in   single-cycle arm pulse, ignored while busy
//   i_abort      in   return to IDLE without a done/error pulse
//   i_rx         in   raw asynchronous RX line
//   o_baud_rate  out  selected baud code (0 = 9600 ... 7 = 921600)
//   o_busy       out  high from accepted start until done/error/abort
//   o_done       out  1-cycle pulse on successful detection
//   o_error      out  1-cycle pulse on out-of-range measurement or timeout

module uart_autobaud #(
    parameter int CLK_FREQ    = 100000000,
    parameter int IDLE_CYCLES = 2 * (CLK_FREQ / 9600)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_rx,
    output logic [2:0] o_baud_rate,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error
);

    // Dividers for codes 0..7
    localparam int D0 = CLK_FREQ / 9600;
    localparam int D1 = CLK_FREQ / 19200;
    localparam int D2 = CLK_FREQ / 38400;
    localparam int D3 = CLK_FREQ / 57600;
    localparam int D4 = CLK_FREQ / 115200;
    localparam int D5 = CLK_FREQ / 230400;
    localparam int D6 = CLK_FREQ / 460800;
    localparam int D7 = CLK_FREQ / 921600;

    // Accepted bit-period window and the measurement timeout (8 slowest periods)
    localparam int P_LO  = D7 - D7 / 4;
    localparam int P_HI  = D0 + D0 / 4;
    localparam int N_MAX = 8 * P_HI;
    localparam int NW    = $clog2(N_MAX + 1);
    localparam int IW    = $clog2(IDLE_CYCLES + 1);

    localparam logic [NW-1:0] P_LO_V      = NW'(P_LO);
    localparam logic [NW-1:0] P_HI_V      = NW'(P_HI);
    localparam logic [NW-1:0] N_LAST_V    = NW'(N_MAX - 1);
    localparam logic [IW-1:0] IDLE_LAST_V = IW'(IDLE_CYCLES - 1);

    // Midpoints between neighbouring dividers
    localparam logic [NW-1:0] T1 = NW'((D0 + D1) / 2);
    localparam logic [NW-1:0] T2 = NW'((D1 + D2) / 2);
    localparam logic [NW-1:0] T3 = NW'((D2 + D3) / 2);
    localparam logic [NW-1:0] T4 = NW'((D3 + D4) / 2);
    localparam logic [NW-1:0] T5 = NW'((D4 + D5) / 2);
    localparam logic [NW-1:0] T6 = NW'((D5 + D6) / 2);
    localparam logic [NW-1:0] T7 = NW'((D6 + D7) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_FALL,
        S_MEASURE,
        S_CLASSIFY
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic [NW-1:0]   r_n;
    logic [NW-1:0]   w_n_nxt;
    logic [2:0]      r_e;
    logic [2:0]      w_e_nxt;
    logic [IW-1:0]   r_idle;
    logic [IW-1:0]   w_idle_nxt;
    logic [2:0]      r_baud;
    logic [2:0]      w_baud_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_error;
    logic            w_error_nxt;
    logic            w_fall;
    logic [NW-1:0]   w_p;
    logic [2:0]      w_code;

    // Input synchronizer plus previous sample for edge detection; all idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall = r_prev & ~r_sync2;

    // Average bit period over the eight measured bit times
    assign w_p = r_n >> 3;

    always_comb begin
        w_code = 3'd7;
        if      (w_p >= T1) w_code = 3'd0;
        else if (w_p >= T2) w_code = 3'd1;
        else if (w_p >= T3) w_code = 3'd2;
        else if (w_p >= T4) w_code = 3'd3;
        else if (w_p >= T5) w_code = 3'd4;
        else if (w_p >= T6) w_code = 3'd5;
        else if (w_p >= T7) w_code = 3'd6;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_e     <= '0;
            r_idle  <= '0;
            r_baud  <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_e     <= w_e_nxt;
            r_idle  <= w_idle_nxt;
            r_baud  <= w_baud_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_error <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_e_nxt     = r_e;
        w_idle_nxt  = r_idle;
        w_baud_nxt  = r_baud;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_error_nxt = 1'b0;

        if (i_abort) begin
            // Abort beats start: a simultaneous start in IDLE is dropped
            if (r_state != S_IDLE) begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = S_WAIT_IDLE;
                        w_idle_nxt  = '0;
                        w_busy_nxt  = 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_sync2) begin
                        if (r_idle == IDLE_LAST_V) begin
                            w_state_nxt = S_WAIT_FALL;
                        end else begin
                            w_idle_nxt = r_idle + 1'b1;
                        end
                    end else begin
                        w_idle_nxt = '0;
                    end
                end
                S_WAIT_FALL: begin
                    if (w_fall) begin
                        w_state_nxt = S_MEASURE;
                        w_n_nxt     = '0;
                        w_e_nxt     = 3'd1;
                    end
                end
                S_MEASURE: begin
                    if (w_fall && (r_e == 3'd4)) begin
                        // Fifth edge: N includes this cycle, i.e. exactly 8 bit times
                        w_state_nxt = S_CLASSIFY;
                        w_n_nxt     = r_n + 1'b1;
                    end else if (r_n == N_LAST_V) begin
                        // N would reach the timeout value; stop before it can wrap
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_n_nxt = r_n + 1'b1;
                        if (w_fall) begin
                            w_e_nxt = r_e + 1'b1;
                        end
                    end
                end
                S_CLASSIFY: begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    if ((w_p < P_LO_V) || (w_p > P_HI_V)) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        w_baud_nxt = w_code;
                        w_done_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign o_baud_rate = r_baud;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule

// File: tb/tb_uart_autobaud.sv
// tb/tb_uart_autobaud.sv - self-checking bench for uart_autobaud

module tb_uart_autobaud;

    localparam int CLK_F = 10000000;
    localparam int IDLE  = 200;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_abort;
    logic       i_rx;
    logic [2:0] o_baud_rate;
    logic       o_busy;
    logic       o_done;
    logic       o_error;

    int checks;
    int errors;
    int cyc;
    int done_cnt;
    int err_cnt;
    int done_cyc;
    int err_cyc;
    int done_busy;
    int err_busy;
    int both_cnt;
    int long_cnt;
    logic prev_done;
    logic prev_err;

    uart_autobaud #(
        .CLK_FREQ   (CLK_F),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_rx       (i_rx),
        .o_baud_rate(o_baud_rate),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Pulse recorder, sampled on the falling edge
    always @(negedge clk) begin
        if (o_done) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = int'(o_busy);
        end
        if (o_error) begin
            err_cnt  = err_cnt + 1;
            err_cyc  = cyc;
            err_busy = int'(o_busy);
        end
        if (o_done && o_error) both_cnt = both_cnt + 1;
        if ((o_done && prev_done) || (o_error && prev_err)) long_cnt = long_cnt + 1;
        prev_done = o_done;
        prev_err  = o_error;
    end

    // Reference model: divider of each rate code and nearest-rate selection
    function automatic int div_of(input int k);
        int rate;
        case (k)
            0: rate = 9600;
            1: rate = 19200;
            2: rate = 38400;
            3: rate = 57600;
            4: rate = 115200;
            5: rate = 230400;
            6: rate = 460800;
            default: rate = 921600;
        endcase
        return CLK_F / rate;
    endfunction

    // Returns the expected code for an average bit period p, or -1 for error
    function automatic int model(input int p);
        int lo;
        int hi;
        lo = div_of(7) - div_of(7) / 4;
        hi = div_of(0) + div_of(0) / 4;
        if (p < lo || p > hi) return -1;
        for (int k = 0; k < 7; k++) begin
            if (p >= (div_of(k) + div_of(k + 1)) / 2) return k;
        end
        return 7;
    endfunction

    function automatic int n_timeout();
        return 8 * (div_of(0) + div_of(0) / 4);
    endfunction

    task automatic clear_mon();
        done_cnt = 0;
        err_cnt  = 0;
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    task automatic drive(input logic v, input int n);
        i_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %0b expected 1", o_busy);
        end
    endtask

    task automatic send_frame(input int b, output int f5);
        logic [9:0] fr;
        fr = {1'b1, 8'h55, 1'b0};
        f5 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) f5 = cyc;
            drive(fr[i], b);
        end
    endtask

    task automatic run_case(input string name, input int b);
        int exp;
        int f5;
        logic [2:0] base;
        exp  = model(b);
        base = o_baud_rate;
        clear_mon();
        drive(1'b1, 4);
        arm();
        drive(1'b1, IDLE + 5);
        send_frame(b, f5);
        drive(1'b1, 8);
        if (exp >= 0) begin
            checks++;
            if (done_cnt !== 1 || err_cnt !== 0) begin
                errors++;
                $display("FAIL %s_pulses: bit=%0d done=%0d err=%0d expected done=1 err=0", name, b, done_cnt, err_cnt);
            end
            checks++;
            if (done_cyc !== f5 + 4) begin
                errors++;
                $display("FAIL %s_done_time: got %0d expected %0d", name, done_cyc, f5 + 4);
            end
            checks++;
            if (int'(o_baud_rate) !== exp) begin
                errors++;
                $display("FAIL %s_code: bit=%0d got %0d expected %0d", name, b, o_baud_rate, exp);
            end
            checks++;
            if (done_busy !== 0) begin
                errors++;
                $display("FAIL %s_busy_at_done: got %0d expected 0", name, done_busy);
            end
        end else begin
            checks++;
            if (err_cnt !== 1 || done_cnt !== 0) begin
                errors++;
                $display("FAIL %s_pulses: bit=%0d done=%0d err=%0d expected done=0 err=1", name, b, done_cnt, err_cnt);
            end
            checks++;
            if (err_cyc !== f5 + 4) begin
                errors++;
                $display("FAIL %s_error_time: got %0d expected %0d", name, err_cyc, f5 + 4);
            end
            checks++;
            if (o_baud_rate !== base) begin
                errors++;
                $display("FAIL %s_code_held: got %0d expected %0d", name, o_baud_rate, base);
            end
            checks++;
            if (err_busy !== 0) begin
                errors++;
                $display("FAIL %s_busy_at_error: got %0d expected 0", name, err_busy);
            end
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after: got %0b expected 0", name, o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_baud_rate !== 3'b000 || o_busy !== 1'b0 || o_done !== 1'b0 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got baud=%0d busy=%0b done=%0b err=%0b expected 0 0 0 0",
                     o_baud_rate, o_busy, o_done, o_error);
        end
        rst = 1'b0;
        drive(1'b1, 3);
    endtask

    task automatic test_directed();
        run_case("bit86", 86);
        run_case("bit128", 128);
        run_case("bit129", 129);
        run_case("bit10", 10);
        run_case("bit8_lower_edge", 8);
        run_case("bit7_too_fast", 7);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_case("random", int'($urandom_range(300, 5)));
        end
    endtask

    task automatic test_timeout();
        int f;
        logic [2:0] base;
        base = o_baud_rate;
        clear_mon();
        drive(1'b1, 4);
        arm();
        drive(1'b1, IDLE + 5);
        f = cyc;
        drive(1'b0, 100);
        // A second start while busy must not restart anything
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_while_busy: busy=%0b expected 1", o_busy);
        end
        drive(1'b0, n_timeout());
        drive(1'b1, 10);
        checks++;
        if (err_cnt !== 1 || done_cnt !== 0) begin
            errors++;
            $display("FAIL timeout_pulses: done=%0d err=%0d expected done=0 err=1", done_cnt, err_cnt);
        end
        checks++;
        if (err_cyc !== f + n_timeout() + 3) begin
            errors++;
            $display("FAIL timeout_time: got %0d expected %0d", err_cyc, f + n_timeout() + 3);
        end
        checks++;
        if (o_baud_rate !== base || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: baud=%0d busy=%0b expected baud=%0d busy=0", o_baud_rate, o_busy, base);
        end
    endtask

    task automatic test_abort();
        logic [2:0] base;
        base = o_baud_rate;
        clear_mon();
        drive(1'b1, 4);
        arm();
        drive(1'b1, IDLE + 5);
        drive(1'b0, 50);
        drive(1'b1, 50);
        drive(1'b0, 50);
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %0b expected 0", o_busy);
        end
        drive(1'b1, 300);
        checks++;
        if (done_cnt !== 0 || err_cnt !== 0 || o_baud_rate !== base) begin
            errors++;
            $display("FAIL abort_quiet: done=%0d err=%0d baud=%0d expected 0 0 %0d", done_cnt, err_cnt, o_baud_rate, base);
        end
        run_case("after_abort_d0", div_of(0));
    endtask

    task automatic test_back_to_back();
        int b1;
        int b2;
        int f5;
        logic [9:0] fr;
        fr = {1'b1, 8'h55, 1'b0};
        b1 = int'($urandom_range(200, 20));
        b2 = int'($urandom_range(200, 20));
        clear_mon();
        drive(1'b1, 4);
        arm();
        drive(1'b1, IDLE + 5);
        for (int i = 0; i < 8; i++) drive(fr[i], b1);
        i_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (o_done !== 1'b1 || int'(o_baud_rate) !== model(b1)) begin
            errors++;
            $display("FAIL b2b_first_done: done=%0b code=%0d expected 1 %0d", o_done, o_baud_rate, model(b1));
        end
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start_on_done: busy=%0b expected 1", o_busy);
        end
        drive(1'b0, b1 - 5);
        drive(1'b1, b1 + IDLE + 5);
        send_frame(b2, f5);
        drive(1'b1, 8);
        checks++;
        if (done_cnt !== 2 || done_cyc !== f5 + 4 || int'(o_baud_rate) !== model(b2)) begin
            errors++;
            $display("FAIL b2b_second: done=%0d at %0d code=%0d expected 2 at %0d code %0d",
                     done_cnt, done_cyc, o_baud_rate, f5 + 4, model(b2));
        end
    endtask

    task automatic test_reset_mid_measure();
        run_case("pre_reset_86", 86);
        clear_mon();
        drive(1'b1, 4);
        arm();
        drive(1'b1, IDLE + 5);
        drive(1'b0, 30);
        drive(1'b1, 30);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (o_baud_rate !== 3'b000 || o_busy !== 1'b0 || o_done !== 1'b0 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_measure: baud=%0d busy=%0b done=%0b err=%0b expected 0 0 0 0",
                     o_baud_rate, o_busy, o_done, o_error);
        end
        drive(1'b1, 300);
        checks++;
        if (done_cnt !== 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_pulse: done=%0d err=%0d expected 0 0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_pulse_shape();
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL done_and_error_together: got %0d expected 0", both_cnt);
        end
        checks++;
        if (long_cnt !== 0) begin
            errors++;
            $display("FAIL pulse_longer_than_one: got %0d expected 0", long_cnt);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        both_cnt  = 0;
        long_cnt  = 0;
        prev_done = 1'b0;
        prev_err  = 1'b0;
        done_busy = 0;
        err_busy  = 0;
        rst       = 1'b1;
        i_start   = 1'b0;
        i_abort   = 1'b0;
        i_rx      = 1'b1;
        clear_mon();
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid_measure();
        test_pulse_shape();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
